cache_way_sched: RTL and testbench
==================================

# cache_way_sched

Clocked scheduler that sequences the 3-way replacement selector in the cache-replacement control path. It accepts one lookup result at a time (hit or miss), picks the target way (the hit way, or the true-LRU victim among unlocked ways on a miss), and drives the one-hot `sel_valid` lines. It issues a single `sel_drive` pulse to the selector, then waits for that way's free acknowledge with a timeout. It owns the per-way LRU age state and reports completion or error per transaction.

## Interface
- `NWAY`, 3: number of ways, legal range 2..8; W = max(1, clog2(NWAY))
- `TIMEOUT`, 15: maximum WAIT cycles before an error, legal range 1..255
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: block is idle and can accept a request
- `req_hit` in 1: 1 = hit (use `req_hit_way`), 0 = miss (choose a victim)
- `req_hit_way` in W: way index, meaningful only when `req_hit`=1
- `way_lock` in NWAY: bit i=1 excludes way i from victim choice (does not affect hits)
- `sel_valid` out NWAY: one-hot select to the selector; stable for the whole transaction
- `sel_drive` out 1: one-cycle drive pulse to the selector
- `sel_free` in NWAY: per-way completion pulse from the selector targets
- `done` out 1: one-cycle completion pulse
- `done_way` out W: way of the finished transaction, valid while `done`=1
- `done_err` out 1: qualifies `done`; 1 = timeout, illegal hit way, or no eligible victim

## Operation
- States: IDLE, CHOOSE, SETUP, DRIVE, WAIT, UPDATE.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch `req_hit`, `req_hit_way` and `way_lock`; go to CHOOSE.
- CHOOSE (`req_ready`=0)
  - Hit with `req_hit_way` < NWAY: target = `req_hit_way`.
  - Hit with `req_hit_way` >= NWAY: error, no selector activity.
  - Miss: target = the unlocked way with the largest age; ties go to the lowest index.
  - Miss with all ways locked: error, no selector activity.
  - On error: go to UPDATE with err flagged.
  - Otherwise: register the one-hot `sel_valid` and go to SETUP.
- SETUP: `sel_valid` held, `sel_drive`=0; always go to DRIVE. This guarantees valid is set up before drive.
- DRIVE: `sel_drive`=1 for exactly this cycle; clear the timer; go to WAIT.
- WAIT
  - Timer increments each cycle.
  - `sel_free[target]`=1: go to UPDATE (success). This includes the cycle in which the timer reaches TIMEOUT; free wins over timeout.
  - `sel_free` bits for non-target ways are ignored.
  - Timer = TIMEOUT with no free: go to UPDATE with err.
- UPDATE
  - `done`=1, `done_way`=target (0 on illegal-hit or no-victim error), `done_err`=flag.
  - `sel_valid` is cleared on exit; go to IDLE.
  - On success only, update ages at the end of this cycle: target age→0; every way whose age was below the target's old age is incremented; other ways are unchanged.
  - On error, ages are unchanged.
- Age registers: NWAY × W bits. After reset, way i age = NWAY-1-i, so way 0 is the first victim. Ages always form a permutation of 0..NWAY-1.
- Requests arriving while `req_ready`=0 are not accepted; the requester holds `req_valid`.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - state = IDLE; `req_ready`=1.
  - `sel_valid`=0, `sel_drive`=0, `done`=0, `done_err`=0, `done_way`=0.
  - Timer = 0; ages = reset permutation.
- Reset mid-transaction aborts immediately: no `done`, `sel_valid` drops asynchronously.
- All outputs are registered except `req_ready`, which is decoded from state.
- Request accepted at edge T (`req_valid`&&`req_ready`):
  - CHOOSE in cycle T+1.
  - `sel_valid` high from T+2 (SETUP) until the end of UPDATE.
  - `sel_drive` high in T+3.
  - WAIT begins at T+4.
- Free seen in WAIT cycle k (k=1 at T+4):
  - `done` in cycle T+4+k.
  - `req_ready`=1 the next cycle; back-to-back throughput is one transaction per 6 cycles minimum.
- Timeout: `done`,`done_err`=1 in cycle T+4+TIMEOUT.
- Error from CHOOSE: `done`,`done_err`=1 in T+2; `sel_valid` and `sel_drive` are never asserted.
- `sel_free` asserted during SETUP or DRIVE is ignored; only WAIT samples it.

## Test plan
- Reset, then miss with `way_lock`=000, free on way 0 in the first WAIT cycle → `sel_valid`=001 at T+2, `sel_drive` pulse at T+3, `done`=1/`done_way`=0/`done_err`=0 at T+5; ages become {0,2,1}.
- Miss, miss, miss from reset, all freed → victims 0, 1, 2 in order; a fourth miss picks way 0 again.
- Hit way 2 from reset (ages {2,1,0}) → `sel_valid`=100, ages become {2,1,0}; next, hit way 0 → ages {0,2,1}.
- Miss with `way_lock`=001 from reset → victim way 1; miss with `way_lock`=111 → `done_err`=1 at T+2, no `sel_drive`, ages unchanged.
- TIMEOUT=15, no free; a free on a wrong way in WAIT is ignored → `done_err`=1 at T+19. Repeat with free at WAIT cycle 15 → success.
- Assert `rst`=0 during WAIT → `sel_valid`=0 immediately, no `done`, ages return to {2,1,0}; a new request after release behaves as from reset.

Source files
------------

// File: rtl/cache_way_sched.sv
// cache_way_sched: sequences one hit/miss lookup at a time into a one-hot way select,
// drive pulse and timed free handshake, keeping true-LRU ages per way.
module cache_way_sched #(
  parameter int NWAY = 3,
  parameter int TIMEOUT = 15,
  localparam int W = (NWAY > 2) ? $clog2(NWAY) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_hit,
  input  logic [W-1:0]    req_hit_way,
  input  logic [NWAY-1:0] way_lock,
  output logic [NWAY-1:0] sel_valid,
  output logic            sel_drive,
  input  logic [NWAY-1:0] sel_free,
  output logic            done,
  output logic [W-1:0]    done_way,
  output logic            done_err
);
  typedef enum logic [2:0] {IDLE, CHOOSE, SETUP, DRIVE, WAIT, UPDATE} state_t;
  state_t          state_q;
  logic            hit_q, err_q;
  logic [W-1:0]    hit_way_q, tgt_q;
  logic [NWAY-1:0] lock_q, sel_valid_q;
  logic [7:0]      timer_q;
  logic [W-1:0]    age_q [NWAY];
  logic            sel_drive_q, done_q, done_err_q;
  logic [W-1:0]    done_way_q;
  logic [W-1:0]    vic_d, best_d, pick_d;
  logic            found_d, bad_d, free_d, tmo_d;
  // Oldest unlocked way; strict compare keeps the lowest index on a tie.
  always_comb begin
    vic_d = '0;
    best_d = '0;
    found_d = 1'b0;
    for (int i = 0; i < NWAY; i++)
      if (!lock_q[i] && (!found_d || age_q[i] > best_d)) begin
        vic_d = W'(i);
        best_d = age_q[i];
        found_d = 1'b1;
      end
  end
  assign bad_d  = hit_q ? ({1'b0, hit_way_q} >= (W+1)'(NWAY)) : !found_d;
  assign pick_d = hit_q ? hit_way_q : vic_d;
  assign free_d = sel_free[tgt_q];
  assign tmo_d  = (timer_q + 8'd1) == 8'(TIMEOUT);
  assign req_ready = state_q == IDLE;
  assign sel_valid = sel_valid_q;
  assign sel_drive = sel_drive_q;
  assign done      = done_q;
  assign done_way  = done_way_q;
  assign done_err  = done_err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      hit_way_q   <= '0;
      tgt_q       <= '0;
      lock_q      <= '0;
      sel_valid_q <= '0;
      sel_drive_q <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      done_way_q  <= '0;
      timer_q     <= '0;
      for (int i = 0; i < NWAY; i++) age_q[i] <= W'(NWAY - 1 - i);
    end else begin
      sel_drive_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          hit_q     <= req_hit;
          hit_way_q <= req_hit_way;
          lock_q    <= way_lock;
          state_q   <= CHOOSE;
        end
        CHOOSE: if (bad_d) begin
          err_q      <= 1'b1;
          tgt_q      <= '0;
          done_q     <= 1'b1;
          done_err_q <= 1'b1;
          done_way_q <= '0;
          state_q    <= UPDATE;
        end else begin
          err_q       <= 1'b0;
          tgt_q       <= pick_d;
          sel_valid_q <= {{(NWAY-1){1'b0}}, 1'b1} << pick_d;
          state_q     <= SETUP;
        end
        SETUP: begin
          sel_drive_q <= 1'b1;
          state_q     <= DRIVE;
        end
        DRIVE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        // A free in the final timer cycle still counts as success.
        WAIT: begin
          timer_q <= timer_q + 8'd1;
          if (free_d || tmo_d) begin
            err_q      <= !free_d;
            done_q     <= 1'b1;
            done_err_q <= !free_d;
            done_way_q <= tgt_q;
            state_q    <= UPDATE;
          end
        end
        UPDATE: begin
          sel_valid_q <= '0;
          done_err_q  <= 1'b0;
          done_way_q  <= '0;
          state_q     <= IDLE;
          if (!err_q)
            for (int i = 0; i < NWAY; i++)
              age_q[i] <= (W'(i) == tgt_q) ? '0 : (age_q[i] < age_q[tgt_q]) ? age_q[i] + 1'b1 : age_q[i];
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_way_sched.sv
// tb_cache_way_sched: directed and randomized checks against an LRU recency-list model.
module tb_cache_way_sched;
  localparam int NWAY = 3;
  localparam int TIMEOUT = 15;
  localparam int W = 2;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_hit = 1'b0;
  logic [W-1:0] req_hit_way = '0;
  logic [NWAY-1:0] way_lock = '0, sel_free = '0;
  logic req_ready, sel_drive, done, done_err;
  logic [NWAY-1:0] sel_valid;
  logic [W-1:0] done_way;
  cache_way_sched #(.NWAY(NWAY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_hit(req_hit), .req_hit_way(req_hit_way), .way_lock(way_lock),
    .sel_valid(sel_valid), .sel_drive(sel_drive), .sel_free(sel_free),
    .done(done), .done_way(done_way), .done_err(done_err));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int order[$];
  int exp_tgt, exp_c, exp_dway;
  bit exp_err, exp_ok, exp_derr;
  logic [NWAY-1:0] exp_sv;
  int sv_first, drv_n, drv_c, done_c, dway;
  bit derr, sv_bad, busy_ready, ready_next, sv_after;
  logic [NWAY-1:0] sv_val;
  // Recency list, most recent first: a way's age is its position in the list.
  function automatic int model_age(input int w);
    foreach (order[j]) if (order[j] == w) return j;
    return -1;
  endfunction
  function automatic void model_reset();
    order.delete();
    for (int i = NWAY - 1; i >= 0; i--) order.push_back(i);
  endfunction
  function automatic void model_touch(input int w);
    foreach (order[j]) if (order[j] == w) begin order.delete(j); break; end
    order.push_front(w);
  endfunction
  function automatic logic [NWAY-1:0] onehot(input int w);
    logic [NWAY-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction
  function automatic void model_pick(input bit hit, input int way, input logic [NWAY-1:0] lock, input int free_k);
    exp_err = 1'b1;
    exp_tgt = 0;
    if (hit) begin
      exp_err = way >= NWAY;
      exp_tgt = exp_err ? 0 : way;
    end else
      for (int j = order.size() - 1; j >= 0; j--)
        if (!lock[order[j]]) begin exp_tgt = order[j]; exp_err = 1'b0; break; end
    exp_ok   = !exp_err && free_k >= 1 && free_k <= TIMEOUT;
    exp_derr = !exp_ok;
    exp_c    = exp_err ? 2 : exp_ok ? 4 + free_k : 4 + TIMEOUT;
    exp_dway = exp_err ? 0 : exp_tgt;
    exp_sv   = exp_err ? '0 : onehot(exp_tgt);
  endfunction
  task automatic do_reset();
    rst = 1'b0;
    req_valid = 1'b0;
    sel_free = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask
  // Drives one transaction and records what the DUT did, cycle 1 being CHOOSE.
  task automatic run_txn(input bit hit, input int way, input logic [NWAY-1:0] lock, input int free_k, input bit noise);
    int c;
    model_pick(hit, way, lock, free_k);
    c = 0;
    @(negedge clk);
    while (!req_ready && c < 10) begin @(negedge clk); c++; end
    if (!req_ready) begin checks++; failures++; $display("FAIL ready_wait: req_ready=%0b want 1", req_ready); end
    req_valid = 1'b1; req_hit = hit; req_hit_way = W'(way); way_lock = lock;
    @(posedge clk);
    #1 req_valid = 1'b0; req_hit = 1'($urandom); req_hit_way = W'($urandom); way_lock = NWAY'($urandom);
    sv_first = 0; drv_n = 0; drv_c = 0; done_c = 0; dway = -1; derr = 1'b0;
    sv_bad = 1'b0; busy_ready = 1'b0; sv_val = '0;
    for (c = 1; c <= 40 && done_c == 0; c++) begin
      sel_free = '0;
      if (noise && (c == 2 || c == 3)) sel_free = onehot(exp_tgt);
      if (noise && c == 5) sel_free = ~onehot(exp_tgt);
      if (free_k > 0 && c == 3 + free_k) sel_free = onehot(exp_tgt);
      @(negedge clk);
      if (req_ready) busy_ready = 1'b1;
      if (sel_valid != '0) begin
        if (sv_first == 0) begin sv_first = c; sv_val = sel_valid; end
        else if (sel_valid !== sv_val) sv_bad = 1'b1;
      end else if (sv_first != 0) sv_bad = 1'b1;
      if (sel_drive) begin drv_n++; drv_c = c; end
      if (done) begin done_c = c; dway = int'(done_way); derr = done_err; end
      @(posedge clk);
      #1;
    end
    sel_free = '0;
    @(negedge clk);
    ready_next = req_ready;
    sv_after = (sel_valid == '0) && !done;
    if (exp_ok) model_touch(exp_tgt);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
    checks++; if (sel_valid !== '0) begin failures++; $display("FAIL rst_sel_valid: got %b want 000", sel_valid); end
    checks++; if ({sel_drive, done, done_err} !== 3'b000) begin failures++; $display("FAIL rst_pulses: got %b want 000", {sel_drive, done, done_err}); end
    checks++; if (done_way !== '0) begin failures++; $display("FAIL rst_done_way: got %0d want 0", done_way); end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < NWAY; i++) begin
      checks++; if (int'(dut.age_q[i]) !== NWAY - 1 - i) begin failures++; $display("FAIL rst_age%0d: got %0d want %0d", i, dut.age_q[i], NWAY - 1 - i); end
    end
  endtask
  task automatic test_miss_basic();
    int ea[NWAY] = '{0, 2, 1};
    do_reset();
    run_txn(1'b0, 0, 3'b000, 1, 1'b0);
    checks++; if (sv_first !== 2) begin failures++; $display("FAIL basic_sv_cycle: got %0d want 2", sv_first); end
    checks++; if (sv_val !== 3'b001) begin failures++; $display("FAIL basic_sv: got %b want 001", sv_val); end
    checks++; if (drv_c !== 3 || drv_n !== 1) begin failures++; $display("FAIL basic_drive: cycle %0d count %0d want cycle 3 count 1", drv_c, drv_n); end
    checks++; if (done_c !== 5) begin failures++; $display("FAIL basic_done_cycle: got %0d want 5", done_c); end
    checks++; if (dway !== 0 || derr !== 1'b0) begin failures++; $display("FAIL basic_done: way %0d err %0b want 0/0", dway, derr); end
    checks++; if (ready_next !== 1'b1 || sv_after !== 1'b1) begin failures++; $display("FAIL basic_after: ready %0b idle %0b want 1/1", ready_next, sv_after); end
    checks++; if (busy_ready !== 1'b0) begin failures++; $display("FAIL basic_busy_ready: got %0b want 0", busy_ready); end
    for (int i = 0; i < NWAY; i++) begin
      checks++; if (int'(dut.age_q[i]) !== ea[i]) begin failures++; $display("FAIL basic_age%0d: got %0d want %0d", i, dut.age_q[i], ea[i]); end
    end
  endtask
  task automatic test_miss_sequence();
    int vic[4] = '{0, 1, 2, 0};
    do_reset();
    for (int n = 0; n < 4; n++) begin
      run_txn(1'b0, 0, 3'b000, 1 + n, 1'b0);
      checks++; if (dway !== vic[n] || derr !== 1'b0) begin failures++; $display("FAIL seq_victim%0d: way %0d err %0b want %0d/0", n, dway, derr, vic[n]); end
      checks++; if (done_c !== 5 + n) begin failures++; $display("FAIL seq_done_cycle%0d: got %0d want %0d", n, done_c, 5 + n); end
    end
  endtask
  task automatic test_hit();
    int ea[NWAY] = '{2, 1, 0};
    int eb[NWAY] = '{0, 2, 1};
    do_reset();
    run_txn(1'b1, 2, 3'b000, 2, 1'b0);
    checks++; if (sv_val !== 3'b100 || dway !== 2 || derr !== 1'b0) begin failures++; $display("FAIL hit2: sv %b way %0d err %0b want 100/2/0", sv_val, dway, derr); end
    for (int i = 0; i < NWAY; i++) begin
      checks++; if (int'(dut.age_q[i]) !== ea[i]) begin failures++; $display("FAIL hit2_age%0d: got %0d want %0d", i, dut.age_q[i], ea[i]); end
    end
    run_txn(1'b1, 0, 3'b111, 1, 1'b0);
    checks++; if (sv_val !== 3'b001 || dway !== 0 || derr !== 1'b0) begin failures++; $display("FAIL hit0_locked: sv %b way %0d err %0b want 001/0/0", sv_val, dway, derr); end
    run_txn(1'b1, 3, 3'b000, 1, 1'b0);
    checks++; if (done_c !== 2 || derr !== 1'b1 || dway !== 0) begin failures++; $display("FAIL hit_illegal: cycle %0d err %0b way %0d want 2/1/0", done_c, derr, dway); end
    checks++; if (drv_n !== 0 || sv_first !== 0) begin failures++; $display("FAIL hit_illegal_quiet: drives %0d sv_cycle %0d want 0/0", drv_n, sv_first); end
    for (int i = 0; i < NWAY; i++) begin
      checks++; if (int'(dut.age_q[i]) !== eb[i]) begin failures++; $display("FAIL hit0_age%0d: got %0d want %0d", i, dut.age_q[i], eb[i]); end
    end
  endtask
  task automatic test_lock();
    int ea[NWAY] = '{2, 0, 1};
    do_reset();
    run_txn(1'b0, 0, 3'b001, 1, 1'b0);
    checks++; if (dway !== 1 || sv_val !== 3'b010) begin failures++; $display("FAIL lock_victim: way %0d sv %b want 1/010", dway, sv_val); end
    run_txn(1'b0, 0, 3'b111, 1, 1'b0);
    checks++; if (done_c !== 2 || derr !== 1'b1 || dway !== 0) begin failures++; $display("FAIL lock_all: cycle %0d err %0b way %0d want 2/1/0", done_c, derr, dway); end
    checks++; if (drv_n !== 0 || sv_first !== 0) begin failures++; $display("FAIL lock_all_quiet: drives %0d sv_cycle %0d want 0/0", drv_n, sv_first); end
    for (int i = 0; i < NWAY; i++) begin
      checks++; if (int'(dut.age_q[i]) !== ea[i]) begin failures++; $display("FAIL lock_age%0d: got %0d want %0d", i, dut.age_q[i], ea[i]); end
    end
  endtask
  task automatic test_timeout();
    int ea[NWAY] = '{2, 0, 1};
    do_reset();
    run_txn(1'b0, 0, 3'b001, 0, 1'b1);
    checks++; if (done_c !== 4 + TIMEOUT || derr !== 1'b1 || dway !== 1) begin failures++; $display("FAIL tmo: cycle %0d err %0b way %0d want %0d/1/1", done_c, derr, dway, 4 + TIMEOUT); end
    checks++; if (int'(dut.age_q[1]) !== 1) begin failures++; $display("FAIL tmo_age1: got %0d want 1", dut.age_q[1]); end
    run_txn(1'b0, 0, 3'b001, TIMEOUT, 1'b1);
    checks++; if (done_c !== 4 + TIMEOUT || derr !== 1'b0 || dway !== 1) begin failures++; $display("FAIL tmo_last_free: cycle %0d err %0b way %0d want %0d/0/1", done_c, derr, dway, 4 + TIMEOUT); end
    checks++; if (sv_bad !== 1'b0) begin failures++; $display("FAIL tmo_sv_stable: got %0b want 0", sv_bad); end
    for (int i = 0; i < NWAY; i++) begin
      checks++; if (int'(dut.age_q[i]) !== ea[i]) begin failures++; $display("FAIL tmo_age%0d: got %0d want %0d", i, dut.age_q[i], ea[i]); end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    run_txn(1'b0, 0, 3'b000, 1, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_hit = 1'b0; way_lock = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++; if (sel_valid !== 3'b010) begin failures++; $display("FAIL mid_pre_sv: got %b want 010", sel_valid); end
    rst = 1'b0;
    #1;
    checks++; if (sel_valid !== '0 || done !== 1'b0) begin failures++; $display("FAIL mid_abort: sv %b done %0b want 000/0", sel_valid, done); end
    sel_free = 3'b010;
    repeat (2) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_hold: done %0b ready %0b want 0/1", done, req_ready); end
    end
    sel_free = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < NWAY; i++) begin
      checks++; if (int'(dut.age_q[i]) !== NWAY - 1 - i) begin failures++; $display("FAIL mid_age%0d: got %0d want %0d", i, dut.age_q[i], NWAY - 1 - i); end
    end
    run_txn(1'b0, 0, 3'b000, 1, 1'b0);
    checks++; if (dway !== 0 || done_c !== 5 || derr !== 1'b0) begin failures++; $display("FAIL mid_after: way %0d cycle %0d err %0b want 0/5/0", dway, done_c, derr); end
  endtask
  task automatic test_random();
    bit hit, noise;
    int way, fk;
    logic [NWAY-1:0] lock;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      hit = ($urandom_range(0, 2) == 0);
      way = $urandom_range(0, NWAY);
      lock = NWAY'($urandom);
      fk = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      noise = 1'($urandom);
      run_txn(hit, way, lock, fk, noise);
      checks++; if (done_c !== exp_c || derr !== exp_derr || dway !== exp_dway) begin failures++; $display("FAIL rnd%0d_done: cycle %0d err %0b way %0d want %0d/%0b/%0d", n, done_c, derr, dway, exp_c, exp_derr, exp_dway); end
      checks++; if (sv_first !== (exp_err ? 0 : 2) || sv_val !== exp_sv || sv_bad !== 1'b0) begin failures++; $display("FAIL rnd%0d_sv: cycle %0d sv %b unstable %0b want %0d/%b/0", n, sv_first, sv_val, sv_bad, exp_err ? 0 : 2, exp_sv); end
      checks++; if (drv_n !== (exp_err ? 0 : 1) || drv_c !== (exp_err ? 0 : 3)) begin failures++; $display("FAIL rnd%0d_drive: count %0d cycle %0d want %0d/%0d", n, drv_n, drv_c, exp_err ? 0 : 1, exp_err ? 0 : 3); end
      checks++; if (busy_ready !== 1'b0 || ready_next !== 1'b1 || sv_after !== 1'b1) begin failures++; $display("FAIL rnd%0d_hs: busy %0b ready %0b idle %0b want 0/1/1", n, busy_ready, ready_next, sv_after); end
      for (int i = 0; i < NWAY; i++) begin
        checks++; if (int'(dut.age_q[i]) !== model_age(i)) begin failures++; $display("FAIL rnd%0d_age%0d: got %0d want %0d", n, i, dut.age_q[i], model_age(i)); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_miss_basic();
    test_miss_sequence();
    test_hit();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
